// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types, requester IDs and width defaults for mem_arbiter
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } arbState_t;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - grant selection; ARB_ROUND_ROBIN_EN alternates on collisions, else data wins
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic lastGrant,
    output logic grant
);

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        if (i_req && d_req) begin
            grant = (lastGrant == REQ_D) ? REQ_I : REQ_D;
        end else begin
            grant = d_req ? REQ_D : REQ_I;
        end
    end
`else
    logic unusedLast;
    assign unusedLast = lastGrant;
    assign grant      = d_req ? REQ_D : REQ_I;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data to single memory port arbiter; ARB_ROUND_ROBIN_EN selects round-robin grant
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_valid,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wmask,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_valid,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_rw,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_data,
    output logic                stall
);

    arbState_t            state;
    logic                 grantQ;
    logic                 rwQ;
    logic [ADDR_W-1:0]    addrQ;
    logic [DATA_W-1:0]    wdataQ;
    logic [DATA_W/8-1:0]  wmaskQ;
    logic                 lastGrant;
    logic                 pickGrant;
    logic                 iWant;
    logic                 dWant;

    // A requester still holding req during its own completion pulse must not be re-granted.
    assign iWant = i_req & ~i_valid;
    assign dWant = d_req & ~d_valid;

    assign stall         = (i_req & ~i_valid) | (d_req & ~d_valid);
    assign mem_req_valid = (state == ISSUE);
    assign mem_rw        = rwQ;
    assign mem_addr      = addrQ;
    assign mem_wdata     = wdataQ;
    assign mem_wmask     = wmaskQ;

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lastGrant <= REQ_I;
        end else if (state == IDLE && (iWant || dWant)) begin
            lastGrant <= pickGrant;
        end
    end
`else
    assign lastGrant = REQ_I;
`endif

    mem_arb_pick u_pick (
        .i_req     (iWant),
        .d_req     (dWant),
        .lastGrant (lastGrant),
        .grant     (pickGrant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            grantQ  <= REQ_I;
            rwQ     <= 1'b0;
            addrQ   <= '0;
            wdataQ  <= '0;
            wmaskQ  <= '0;
            i_valid <= 1'b0;
            d_valid <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            i_valid <= 1'b0;
            d_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (iWant || dWant) begin
                        grantQ <= pickGrant;
                        state  <= ISSUE;
                        if (pickGrant == REQ_D) begin
                            rwQ    <= d_we;
                            addrQ  <= d_addr;
                            wdataQ <= d_wdata;
                            wmaskQ <= d_wmask;
                        end else begin
                            rwQ    <= 1'b0;
                            addrQ  <= i_addr;
                            wdataQ <= '0;
                            wmaskQ <= '0;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_req_ready) begin
                        if (rwQ) begin
                            state   <= IDLE;
                            d_valid <= 1'b1;
                        end else begin
                            state <= WAIT_RESP;
                        end
                    end
                end
                WAIT_RESP: begin
                    if (mem_resp_valid) begin
                        state <= IDLE;
                        if (grantQ == REQ_D) begin
                            d_rdata <= mem_resp_data;
                            d_valid <= 1'b1;
                        end else begin
                            i_rdata <= mem_resp_data;
                            i_valid <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        iReq, dReq, dWe;
    logic [31:0] iAddr, dAddr, dWdata;
    logic [3:0]  dWmask;
    logic        memReady, respValid;
    logic [31:0] respData;

    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic        i_valid, d_valid, mem_req_valid, mem_rw, stall;

    int          nChecks = 0;
    int          nPass = 0;
    logic [31:0] iLast = '0;
    logic [31:0] dLast = '0;
    bit          lastD = 1'b0;

    mem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .i_req          (iReq),
        .i_addr         (iAddr),
        .i_rdata        (i_rdata),
        .i_valid        (i_valid),
        .d_req          (dReq),
        .d_we           (dWe),
        .d_addr         (dAddr),
        .d_wdata        (dWdata),
        .d_wmask        (dWmask),
        .d_rdata        (d_rdata),
        .d_valid        (d_valid),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (memReady),
        .mem_rw         (mem_rw),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (respValid),
        .mem_resp_data  (respData),
        .stall          (stall)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Entered at the first negedge after the grant edge; returns at the completion-pulse negedge.
    task automatic runTxn(input bit isD, input bit isWr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] wm, input int rdy, input int rsp, input bit drop,
                          input logic [31:0] rd);
        for (int k = 0; k <= rdy; k++) begin
            checkEq("cmd_valid", mem_req_valid, 1);
            checkEq("cmd_addr", mem_addr, addr);
            checkEq("cmd_rw", mem_rw, isWr);
            if (isWr) begin
                checkEq("cmd_wdata", mem_wdata, wd);
                checkEq("cmd_wmask", mem_wmask, wm);
            end
            checkEq("early_valid", {i_valid, d_valid}, 0);
            checkEq("stall_busy", stall, iReq | dReq);
            if (k == rdy) memReady = 1'b1;
            if (drop && k == 0) begin
                if (isD) dReq = 1'b0;
                else     iReq = 1'b0;
            end
            @(negedge clk);
        end
        memReady = 1'b0;
        if (!isWr) begin
            for (int k = 0; k < rsp; k++) begin
                checkEq("resp_wait", {mem_req_valid, i_valid, d_valid}, 0);
                @(negedge clk);
            end
            respValid = 1'b1;
            respData  = rd;
            @(negedge clk);
            respValid = 1'b0;
            if (isD) dLast = rd;
            else     iLast = rd;
        end
        checkEq("valid_pulse", {i_valid, d_valid}, isD ? 2'b01 : 2'b10);
        checkEq("i_rdata", i_rdata, iLast);
        checkEq("d_rdata", d_rdata, dLast);
        checkEq("cmd_idle", mem_req_valid, 0);
        checkEq("stall_pulse", stall, isD ? iReq : dReq);
    endtask

    task automatic doRound(input bit wantI, input bit wantD, input logic [31:0] iA, input logic [31:0] dA,
                           input bit dW, input logic [31:0] dWd, input logic [3:0] dM,
                           input int rdyI, input int rspI, input int rdyD, input int rspD,
                           input bit dropI, input bit dropD);
        bit          winD, curD, both;
        logic [31:0] rdI, rdD;
        rdI    = $urandom;
        rdD    = $urandom;
        both   = wantI && wantD;
        iReq   = wantI;
        iAddr  = iA;
        dReq   = wantD;
        dWe    = dW;
        dAddr  = dA;
        dWdata = dWd;
        dWmask = dM;
        @(negedge clk);
        if (both) winD = RR ? !lastD : 1'b1;
        else      winD = wantD;
        for (int n = 0; n < (both ? 2 : 1); n++) begin
            curD  = (n == 0) ? winD : !winD;
            lastD = curD;
            runTxn(curD, curD & dW, curD ? dA : iA, dWd, dM, curD ? rdyD : rdyI,
                   curD ? rspD : rspI, curD ? dropD : dropI, curD ? rdD : rdI);
            @(posedge clk);
            #1;
            if (curD) dReq = 1'b0;
            else      iReq = 1'b0;
            @(negedge clk);
            checkEq("pulse_once", {i_valid, d_valid}, 0);
            if (n == 1 || !both) begin
                checkEq("no_double", mem_req_valid, 0);
                checkEq("stall_idle", stall, 0);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; iReq = 0; dReq = 0; dWe = 0; iAddr = 0; dAddr = 0; dWdata = 0; dWmask = 0;
        memReady = 0; respValid = 0; respData = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkEq("rst_mem_req_valid", mem_req_valid, 0);
        checkEq("rst_valids", {i_valid, d_valid}, 0);
        checkEq("rst_i_rdata", i_rdata, 0);
        checkEq("rst_d_rdata", d_rdata, 0);
        checkEq("rst_stall", stall, 0);
        rst = 1'b0;
        @(negedge clk);

        doRound(1, 0, 32'h100, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0);
        doRound(1, 1, 32'h100, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        doRound(1, 1, 32'h104, 32'h204, 0, 0, 0, 1, 0, 0, 1, 0, 0);
        doRound(0, 1, 0, 32'h300, 1, 32'h12345678, 4'hF, 0, 0, 3, 0, 0, 0);

        respValid = 1'b1;
        respData  = 32'hCAFEF00D;
        @(negedge clk);
        respValid = 1'b0;
        checkEq("idle_resp_valids", {i_valid, d_valid}, 0);
        checkEq("idle_resp_i_rdata", i_rdata, iLast);
        checkEq("idle_resp_d_rdata", d_rdata, dLast);
        checkEq("idle_resp_cmd", mem_req_valid, 0);

        for (int r = 0; r < 40; r++) begin
            int kind;
            kind = $urandom_range(0, 3);
            doRound(kind != 1, kind != 0, $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
                    $urandom_range(0, 1), $urandom, 4'($urandom_range(1, 15)),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end

        iReq  = 1'b1;
        iAddr = 32'h400;
        @(negedge clk);
        memReady = 1'b1;
        @(negedge clk);
        memReady = 1'b0;
        checkEq("wait_cmd_low", mem_req_valid, 0);
        rst  = 1'b1;
        iReq = 1'b0;
        #1;
        checkEq("rst_mid_valids", {i_valid, d_valid}, 0);
        checkEq("rst_mid_cmd", mem_req_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        respValid = 1'b1;
        respData  = 32'hBAD0BAD0;
        @(negedge clk);
        respValid = 1'b0;
        checkEq("late_resp_valids", {i_valid, d_valid}, 0);
        checkEq("late_resp_i_rdata", i_rdata, 0);
        checkEq("late_resp_cmd", mem_req_valid, 0);
        @(negedge clk);
        checkEq("late_resp_after", {mem_req_valid, i_valid, d_valid}, 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
